// File: rtl/led_pwm_cmd_ctrl.sv
// UART command decoder driving NUM_CH PWM channels: 3-byte 'S'et/'G'et commands
// update double-buffered duty registers, with a one-byte reply per command.
module led_pwm_cmd_ctrl #(
  parameter int NUM_CH         = 3,
  parameter int PWM_BITS       = 8,
  parameter int PRESCALE       = 188,
  parameter int TIMEOUT_CYCLES = 4_800_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rcv_data,
  input  logic              rcv_ready,
  input  logic              snd_busy,
  output logic [7:0]        snd_data,
  output logic              snd_ready,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [7:0] OP_SET = 8'h53;
  localparam logic [7:0] OP_GET = 8'h47;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_ER = 8'h45;

  typedef enum logic [2:0] {IDLE, GOT_OP, GOT_CH, RESP_WAIT, RESP_SEND} state_t;

  state_t              state, state_nxt;
  logic [7:0]          op_q, ch_q;
  logic [TO_W-1:0]     to_cnt;
  logic [PWM_BITS-1:0] shadow [NUM_CH];
  logic [PWM_BITS-1:0] active [NUM_CH];
  logic [PS_W-1:0]     pre;
  logic [PWM_BITS-1:0] cnt;
  logic                tick;
  logic                ch_valid, to_expired, waiting;
  logic                reply_load, shadow_we;
  logic [7:0]          reply_nxt, rd_val;

  assign ch_valid   = int'(ch_q) < NUM_CH;
  assign waiting    = (state == GOT_OP) || (state == GOT_CH);
  assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign tick       = (pre == PS_W'(PRESCALE - 1));

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (ch_q == 8'(i)) rd_val = 8'(shadow[i]);
  end

  always_comb begin
    state_nxt  = state;
    reply_load = 1'b0;
    reply_nxt  = snd_data;
    shadow_we  = 1'b0;
    case (state)
      IDLE: if (rcv_ready) begin
        if (rcv_data == OP_SET || rcv_data == OP_GET) begin
          state_nxt = GOT_OP;
        end else begin
          state_nxt  = RESP_WAIT;
          reply_load = 1'b1;
          reply_nxt  = RSP_ER;
        end
      end
      GOT_OP: begin
        if (rcv_ready)       state_nxt = GOT_CH;
        else if (to_expired) state_nxt = IDLE;
      end
      GOT_CH: begin
        if (rcv_ready) begin
          state_nxt  = RESP_WAIT;
          reply_load = 1'b1;
          if (!ch_valid) begin
            reply_nxt = RSP_ER;
          end else if (op_q == OP_SET) begin
            reply_nxt = RSP_OK;
            shadow_we = 1'b1;
          end else begin
            reply_nxt = rd_val;
          end
        end else if (to_expired) begin
          state_nxt = IDLE;
        end
      end
      RESP_WAIT: if (!snd_busy) state_nxt = RESP_SEND;
      RESP_SEND: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= '0;
      ch_q      <= '0;
      to_cnt    <= '0;
      snd_data  <= '0;
      snd_ready <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && rcv_ready)   op_q <= rcv_data;
      if (state == GOT_OP && rcv_ready) ch_q <= rcv_data;
      if (waiting && !rcv_ready && !to_expired) to_cnt <= to_cnt + 1'b1;
      else                                      to_cnt <= '0;
      if (reply_load) snd_data <= reply_nxt;
      // Registered strobe: fires the cycle after RESP_SEND, giving the 2-cycle reply latency.
      snd_ready <= (state == RESP_SEND);
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (shadow_we && ch_q == 8'(i)) shadow[i] <= PWM_BITS'(rcv_data);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre     <= '0;
      cnt     <= '0;
      pwm_out <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) active[i] <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) begin
        if (cnt == CNT_MAX) begin
          cnt <= '0;
          // Duties latch only at the period boundary so a pulse is never cut or stretched.
          for (int unsigned i = 0; i < NUM_CH; i++) active[i] <= shadow[i];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      for (int unsigned i = 0; i < NUM_CH; i++) pwm_out[i] <= (cnt < active[i]);
    end
  end

endmodule

// File: tb/tb_led_pwm_cmd_ctrl.sv
// Directed bench: replies are scoreboarded (byte and arrival cycle) by a monitor,
// PWM duty and pulse widths are measured directly from pwm_out.
module tb_led_pwm_cmd_ctrl;

  localparam int NUM_CH   = 3;
  localparam int PRESCALE = 2;
  localparam int PER      = 255 * PRESCALE;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        rcv_data = '0;
  logic              rcv_ready = 1'b0;
  logic              snd_busy = 1'b0;
  logic [7:0]        snd_data;
  logic              snd_ready;
  logic [NUM_CH-1:0] pwm_out;

  led_pwm_cmd_ctrl #(
    .NUM_CH(NUM_CH), .PWM_BITS(8), .PRESCALE(PRESCALE), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .rcv_data(rcv_data), .rcv_ready(rcv_ready),
    .snd_busy(snd_busy), .snd_data(snd_data), .snd_ready(snd_ready), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int at; } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    if (reset && snd_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_reply: got data 0x%02h at cycle %0d, none expected", snd_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (snd_data !== e.d) begin
          n_bad++;
          $display("FAIL reply_data: got 0x%02h, expected 0x%02h", snd_data, e.d);
        end
        n_cmp++;
        if (cyc != e.at) begin
          n_bad++;
          $display("FAIL reply_cycle: got cycle %0d, expected %0d", cyc, e.at);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int edge_n);
    @(posedge clk); #1;
    rcv_data = b; rcv_ready = 1'b1;
    @(posedge clk); #1;
    edge_n = cyc;
    rcv_ready = 1'b0;
  endtask

  task automatic cmd3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] rsp);
    int n;
    send_byte(b0, n);
    send_byte(b1, n);
    send_byte(b2, n);
    exp_q.push_back('{d: rsp, at: n + 2});
    repeat (5) @(posedge clk);
  endtask

  task automatic cmd1(input logic [7:0] b0, input logic [7:0] rsp);
    int n;
    send_byte(b0, n);
    exp_q.push_back('{d: rsp, at: n + 2});
    repeat (5) @(posedge clk);
  endtask

  task automatic measure(input int ch, output int hi);
    hi = 0;
    repeat (PER) begin
      @(negedge clk);
      if (pwm_out[ch]) hi++;
    end
  endtask

  task automatic wait_level(input int ch, input logic lvl, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int k = 0; k < 2 * PER; k++) begin
      @(negedge clk);
      if (pwm_out[ch] === lvl) begin
        ok = 1'b1; at = cyc; break;
      end
    end
  endtask

  initial begin
    int hi, n, bstart, r, f, r2, f2;
    bit ok;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pwm_out", int'(pwm_out), 0);
    check("reset_snd_ready", int'(snd_ready), 0);
    check("reset_snd_data", int'(snd_data), 0);
    #2 reset = 1'b1;

    hi = 0;
    repeat (3 * PER) begin
      @(negedge clk);
      if (pwm_out != '0) hi++;
    end
    check("idle_pwm_low_cycles", hi, 0);

    cmd3(8'h53, 8'h01, 8'h80, 8'h4B);
    repeat (2 * PER) @(posedge clk);
    measure(1, hi); check("ch1_duty80_high", hi, 128 * PRESCALE);
    measure(0, hi); check("ch0_idle_high", hi, 0);
    measure(2, hi); check("ch2_idle_high", hi, 0);

    cmd3(8'h53, 8'h00, 8'hFF, 8'h4B);
    cmd3(8'h53, 8'h02, 8'h00, 8'h4B);
    repeat (2 * PER) @(posedge clk);
    measure(0, hi); check("ch0_dutyFF_high", hi, PER);
    measure(2, hi); check("ch2_duty00_high", hi, 0);
    cmd3(8'h47, 8'h00, 8'h00, 8'hFF);

    cmd1(8'h41, 8'h45);
    cmd3(8'h53, 8'h03, 8'h10, 8'h45);
    cmd3(8'h47, 8'h01, 8'h00, 8'h80);
    cmd3(8'h47, 8'h02, 8'h00, 8'h00);

    send_byte(8'h53, n);
    send_byte(8'h00, n);
    repeat (300) @(posedge clk);
    cmd3(8'h47, 8'h00, 8'h00, 8'hFF);

    @(posedge clk); #1 snd_busy = 1'b1;
    bstart = cyc;
    send_byte(8'h47, n);
    send_byte(8'h01, n);
    send_byte(8'h00, n);
    repeat (200) @(posedge clk);
    send_byte(8'h47, n);
    while (cyc < bstart + 500) @(posedge clk);
    #1 snd_busy = 1'b0;
    exp_q.push_back('{d: 8'h80, at: cyc + 2});
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("snd_data_held", int'(snd_data), 8'h80);
    cmd3(8'h47, 8'h00, 8'h00, 8'hFF);

    wait_level(1, 1'b0, r, ok);
    check("wait_ch1_low", int'(ok), 1);
    wait_level(1, 1'b1, r, ok);
    check("wait_ch1_rise", int'(ok), 1);
    repeat (40) @(negedge clk);
    cmd3(8'h53, 8'h01, 8'h10, 8'h4B);
    wait_level(1, 1'b0, f, ok);
    check("old_pulse_width", f - r, 128 * PRESCALE);
    wait_level(1, 1'b1, r2, ok);
    wait_level(1, 1'b0, f2, ok);
    check("new_pulse_width", f2 - r2, 16 * PRESCALE);
    check("new_pulse_start", r2 - r, PER);

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    check("replies_outstanding", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
